// File: rtl/por_seq.sv
// por_seq: multi-channel power-on reset sequencer.
//
// After reset_n is released the block waits INIT_DELAY cycles, then takes
// run[0] .. run[CHANNELS-1] out of reset one at a time, STAGE_DELAY+1 cycles
// apart. A re-reset request (sw_reset_req or a button event on ext_reset_n)
// puts the channels back into reset in the reverse order, then restarts the
// settling delay and the release sequence.
//
// Build option: define POR_SEQ_DEBOUNCE_EN to debounce the button. The
// synchronised button must then read low for DEBOUNCE_CYCLES consecutive edges
// before it counts. Without the macro every falling edge of the synchronised
// button is an event and DEBOUNCE_CYCLES is unused.
//
// dbg_state shows the sequencer state: 0 INIT, 1 UP, 2 RUN, 3 DOWN.

module por_seq #(
   parameter int CHANNELS        = 3,
   parameter int INIT_DELAY      = 1562500,
   parameter int STAGE_DELAY     = 25000,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 24
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                ext_reset_n,
   input  logic                sw_reset_req,
   output logic [CHANNELS-1:0] run,
   output logic                all_running,
   output logic                busy,
   output logic [1:0]          dbg_state
);

   // Request semantics: sw_reset_req is a plain level sampled on every rising
   // edge. Each edge it reads high is one request, and there is no
   // acknowledge. Requests that arrive during DOWN are dropped. ext events
   // are single-cycle pulses, so one button press makes exactly one request.

   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(INIT_DELAY);
   localparam logic [CNT_W-1:0] STAGE_LOAD = CNT_W'(STAGE_DELAY);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CHANNELS - 1);
   localparam logic [IDX_W-1:0] TOP_DOWN   = IDX_W'((CHANNELS > 1) ? (CHANNELS - 2) : 0);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_UP   = 2'd1,
      ST_RUN  = 2'd2,
      ST_DOWN = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Button path: two-flop synchroniser, then conditioning
   // ------------------------------------------------------------------
   logic sync1_q;
   logic sync2_q;
   logic ext_lvl;    // conditioned button level, low = held in reset
   logic ext_evt_q;  // one-cycle pulse per button press

   // Bring the asynchronous button into the clock domain. Both flops idle high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= ext_reset_n;
         sync2_q <= sync1_q;
      end
   end

`ifdef POR_SEQ_DEBOUNCE_EN
   localparam int DBC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [DBC_W-1:0] DBC_LAST =
      DBC_W'((DEBOUNCE_CYCLES > 0) ? (DEBOUNCE_CYCLES - 1) : 0);

   logic [DBC_W-1:0] dbc_q;
   logic             lvl_q;

   // Count consecutive low samples. The level drops and one event fires when
   // the run of low samples reaches DEBOUNCE_CYCLES. The first high sample
   // restores the level at once, so release needs no debounce.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dbc_q     <= '0;
         lvl_q     <= 1'b1;
         ext_evt_q <= 1'b0;
      end else begin
         ext_evt_q <= 1'b0;
         if (sync2_q) begin
            dbc_q <= '0;
            lvl_q <= 1'b1;
         end else if (lvl_q) begin
            if (dbc_q == DBC_LAST) begin
               lvl_q     <= 1'b0;
               ext_evt_q <= 1'b1;
            end else begin
               dbc_q <= dbc_q + DBC_W'(1);
            end
         end
      end
   end

   assign ext_lvl = lvl_q;
`else
   logic sync2_prev_q;

   // Detect a falling edge on the synchronised button. The event is
   // registered, so the sequencer reacts one edge after the low sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync2_prev_q <= 1'b1;
         ext_evt_q    <= 1'b0;
      end else begin
         sync2_prev_q <= sync2_q;
         ext_evt_q    <= sync2_prev_q & ~sync2_q;
      end
   end

   assign ext_lvl = sync2_q;
`endif

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   state_t               state_q;
   state_t               state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic [IDX_W-1:0]     idx_q;   // UP: next channel to release; DOWN: next to assert
   logic [IDX_W-1:0]     idx_d;
   logic [CHANNELS-1:0]  run_q;
   logic [CHANNELS-1:0]  run_d;
   logic                 all_q;
   logic                 busy_q;

   logic                 rerun_req;
   logic                 cnt_zero;
   logic [CNT_W-1:0]     cnt_dec;

   assign rerun_req = sw_reset_req | ext_evt_q;
   assign cnt_zero  = (cnt_q == '0);
   assign cnt_dec   = cnt_q - CNT_W'(1);

   // State, counter and registered outputs. Reset drives every output
   // immediately, without waiting for a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_INIT;
         cnt_q   <= INIT_LOAD;
         idx_q   <= '0;
         run_q   <= '0;
         all_q   <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         run_q   <= run_d;
         all_q   <= (state_d == ST_RUN);
         busy_q  <= (state_d != ST_RUN);
      end
   end

   // Next state. The counter steps down once per edge, and a transition fires
   // on the edge at which it reads zero. A request takes priority over a
   // transition that falls on the same edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      run_d   = run_q;

      case (state_q)
         ST_INIT: begin
            if (rerun_req || !ext_lvl) begin
               // Restart settling, or hold it while the button is down.
               cnt_d = INIT_LOAD;
            end else if (cnt_zero) begin
               run_d[0] = 1'b1;
               cnt_d    = STAGE_LOAD;
               if (CHANNELS == 1) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_UP;
                  idx_d   = IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_dec;
            end
         end

         ST_UP: begin
            if (rerun_req) begin
               // Assert the most recently released channel now. If that was
               // run[0], nothing is left to assert, so settling restarts.
               run_d[idx_q - IDX_W'(1)] = 1'b0;
               if (idx_q == IDX_W'(1)) begin
                  state_d = ST_INIT;
                  cnt_d   = INIT_LOAD;
               end else begin
                  state_d = ST_DOWN;
                  idx_d   = idx_q - IDX_W'(2);
                  cnt_d   = STAGE_LOAD;
               end
            end else if (cnt_zero) begin
               run_d[idx_q] = 1'b1;
               cnt_d        = STAGE_LOAD;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_RUN;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_dec;
            end
         end

         ST_RUN: begin
            if (rerun_req) begin
               run_d[CHANNELS-1] = 1'b0;
               if (CHANNELS == 1) begin
                  state_d = ST_INIT;
                  cnt_d   = INIT_LOAD;
               end else begin
                  state_d = ST_DOWN;
                  idx_d   = TOP_DOWN;
                  cnt_d   = STAGE_LOAD;
               end
            end
         end

         ST_DOWN: begin
            // Requests are dropped here; the shutdown always completes.
            if (cnt_zero) begin
               run_d[idx_q] = 1'b0;
               if (idx_q == '0) begin
                  state_d = ST_INIT;
                  cnt_d   = INIT_LOAD;
               end else begin
                  idx_d = idx_q - IDX_W'(1);
                  cnt_d = STAGE_LOAD;
               end
            end else begin
               cnt_d = cnt_dec;
            end
         end

         default: begin
            state_d = ST_INIT;
            cnt_d   = INIT_LOAD;
         end
      endcase
   end

   assign run         = run_q;
   assign all_running = all_q;
   assign busy        = busy_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_por_seq.sv
// Testbench for por_seq.
//
// A reference model predicts the expected outputs from timing formulas. The
// formulas give how many channels are out of reset at each edge, counted from
// the start of settling or from the edge of a request. Each expected output
// change is queued as {edge, value}. A separate monitor compares every change
// it sees on the outputs against the head of the queue.

module tb_por_seq;

   localparam int C   = 3;
   localparam int INI = 10;
   localparam int STG = 4;
   localparam int DBC = 5;
   localparam int V   = C + 2;
   localparam int W   = 32 + V;

`ifdef POR_SEQ_DEBOUNCE_EN
   localparam int EXT_LAT = DBC + 2;
`else
   localparam int EXT_LAT = 3;
`endif

   localparam logic [V-1:0] RST_VAL = {{C{1'b0}}, 1'b0, 1'b1};

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         reset_n;
   logic         ext_reset_n;
   logic         sw_reset_req;
   logic [C-1:0] run;
   logic         all_running;
   logic         busy;
   logic [1:0]   dbg_state;

   always #5 clk = ~clk;

   por_seq #(
      .CHANNELS(C),
      .INIT_DELAY(INI),
      .STAGE_DELAY(STG),
      .DEBOUNCE_CYCLES(DBC),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .ext_reset_n(ext_reset_n),
      .sw_reset_req(sw_reset_req),
      .run(run),
      .all_running(all_running),
      .busy(busy),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int             checks = 0;
   int             errors = 0;
   int             edge_n = 0;
   logic [W-1:0]   exp_q[$];
   int             req_q[$];

   // Model: either rising from settle start f0, or falling from request
   // edge e0 with n0 channels out of reset at that moment.
   bit             falling  = 1'b0;
   int             f0       = 0;
   int             e0       = 0;
   int             n0       = 0;
   logic [V-1:0]   last_exp = RST_VAL;
   logic [V-1:0]   last_obs = RST_VAL;

   // Output vector when n channels are out of reset.
   function automatic logic [V-1:0] pack_n(int n);
      logic [C-1:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[i] = 1'b1;
      return {r, (n == C), (n != C)};
   endfunction

   // Number of channels out of reset just after edge t.
   function automatic int n_at(int t);
      int f;
      int k;
      if (falling) begin
         f = e0 + (n0 - 1) * (STG + 1);
         if (t < f) return n0 - ((t - e0) / (STG + 1) + 1);
      end else begin
         f = f0;
      end
      if (t < f + INI + 1) return 0;
      k = (t - f - INI - 1) / (STG + 1) + 1;
      return (k > C) ? C : k;
   endfunction

   // True while the channels are being put back into reset after edge t.
   function automatic bit in_down(int t);
      return falling && (t >= e0) && (t < e0 + (n0 - 1) * (STG + 1));
   endfunction

   // Apply a request sampled at edge e.
   task automatic apply_req(int e);
      int n;
      if (in_down(e - 1)) return;
      n = n_at(e - 1);
      if (n == 0) begin
         falling = 1'b0;
         f0      = e;
      end else begin
         falling = 1'b1;
         e0      = e;
         n0      = n;
      end
   endtask

   // Model process: at every edge, queue any change in the expected outputs.
   always begin
      logic [V-1:0] val;
      @(posedge clk);
      if (!reset_n) begin
         edge_n   = 0;
         falling  = 1'b0;
         f0       = 0;
         last_exp = RST_VAL;
         req_q.delete();
      end else begin
         edge_n = edge_n + 1;
         #1;
         if (req_q.size() > 0 && req_q[0] == edge_n) begin
            void'(req_q.pop_front());
            apply_req(edge_n);
         end
         val = pack_n(n_at(edge_n));
         if (val != last_exp) begin
            exp_q.push_back({32'(edge_n), val});
            last_exp = val;
         end
      end
   end

   // Monitor: on every output change, pop one expectation and compare.
   always begin
      logic [V-1:0] obs;
      logic [W-1:0] e;
      @(negedge clk);
      if (!reset_n) begin
         last_obs = RST_VAL;
      end else begin
         obs = {run, all_running, busy};
         if (obs !== last_obs) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
               errors = errors + 1;
               $display("FAIL unexpected_change edge %0d got %b want %b", edge_n, obs, last_obs);
            end else begin
               e = exp_q.pop_front();
               if (e[V-1:0] !== obs || int'(e[W-1:V]) != edge_n) begin
                  errors = errors + 1;
                  $display("FAIL transition edge %0d got run/all/busy=%b want %b at edge %0d",
                           edge_n, obs, e[V-1:0], int'(e[W-1:V]));
               end
            end
            last_obs = obs;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_edge(int t);
      int guard;
      guard = 0;
      while (edge_n < t && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (edge_n < t) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL wait_edge timeout at edge %0d want %0d", edge_n, t);
      end
   endtask

   task automatic check_outputs(string name);
      checks = checks + 3;
      if (run !== '0) begin
         errors = errors + 1;
         $display("FAIL %s_run got %b want 0", name, run);
      end
      if (all_running !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL %s_all_running got %b want 0", name, all_running);
      end
      if (busy !== 1'b1) begin
         errors = errors + 1;
         $display("FAIL %s_busy got %b want 1", name, busy);
      end
   endtask

   task automatic check_drained(string name);
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL %s_missing got %0d pending changes want 0 (next at edge %0d)",
                  name, exp_q.size(), int'(exp_q[0][W-1:V]));
         exp_q.delete();
      end
   endtask

   // Pull reset_n low between edges, check outputs without a clock edge.
   task automatic async_reset(string name);
      #2 reset_n = 1'b0;
      #1 check_outputs(name);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Request sampled at edge e.
   task automatic sw_pulse(int e);
      wait_edge(e - 1);
      sw_reset_req = 1'b1;
      req_q.push_back(e);
      @(negedge clk);
      sw_reset_req = 1'b0;
   endtask

   // Button low for len edges starting at edge a.
   task automatic ext_pulse(int a, int len, bit expect_evt);
      wait_edge(a - 1);
      ext_reset_n = 1'b0;
      if (expect_evt) req_q.push_back(a + EXT_LAT);
      repeat (len) @(negedge clk);
      ext_reset_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at edge %0d", edge_n);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int e;
      reset_n      = 1'b0;
      ext_reset_n  = 1'b1;
      sw_reset_req = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs("reset");
      reset_n = 1'b1;

      // Power-up: 001 @11, 011 @16, 111 @21.
      wait_edge(25);
      check_drained("power_up");

      // Software re-reset sampled at edge 30.
      sw_pulse(30);
      wait_edge(70);
      check_drained("sw_rereset");

      // Request during UP at edge 18; the second at 20 falls in DOWN.
      async_reset("reset_run");
      sw_pulse(18);
      sw_pulse(20);
      wait_edge(50);
      check_drained("up_request");

      // Async reset in the middle of DOWN, then the release pattern again.
      sw_pulse(55);
      wait_edge(57);
      async_reset("reset_down");
      wait_edge(25);
      check_drained("after_async");

      // Button while running.
`ifdef POR_SEQ_DEBOUNCE_EN
      ext_pulse(30, 3, 1'b0);
      wait_edge(45);
      check_drained("ext_glitch");
      ext_pulse(50, 8, 1'b1);
      wait_edge(100);
      check_drained("ext_debounced");
`else
      ext_pulse(30, 1, 1'b1);
      wait_edge(70);
      check_drained("ext_pulse");
`endif

      // Random requests landing in INIT, UP, RUN and DOWN.
      for (int i = 0; i < 40; i++) begin
         e = edge_n + 1 + $urandom_range(1, 30);
         if (!in_down(e - 1) && n_at(e - 1) == 1) e = e + STG + 1;
         sw_pulse(e);
      end
      wait_edge(edge_n + INI + 2 * C * (STG + 1) + 5);
      check_drained("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
